// File: rtl/pio_pkg.sv
// Shared constants for the Avalon PIO extension: register offsets and
// capture-edge encodings.
package pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_INPUT    = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    localparam logic [1:0] EDGE_RISE = 2'd0;
    localparam logic [1:0] EDGE_FALL = 2'd1;
    localparam logic [1:0] EDGE_ANY  = 2'd2;

endpackage

// File: rtl/avalon_pio_ext_if.sv
// Avalon-MM slave bus bundle for the PIO extension (32-bit data, 3-bit word address).
interface avalon_pio_ext_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/pio_edge_detect.sv
// Input synchroniser, one-cycle delay flop and edge filter; emits a one-cycle
// edge pulse per bit once the pipeline holds only post-reset samples.
module pio_edge_detect
    import pio_pkg::*;
#(
    parameter int WIDTH       = 18,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] edge_pulse
);

    localparam logic [1:0] ETYPE = 2'(EDGE_TYPE);

    logic [WIDTH-1:0]     sync_r [SYNC_STAGES];
    logic [WIDTH-1:0]     dly_r;
    // Tracks which pipeline stages hold real samples, so reset zeros never look like edges.
    logic [SYNC_STAGES:0] vld_r;
    logic [WIDTH-1:0]     cur_s;

    assign cur_s    = sync_r[SYNC_STAGES-1];
    assign sync_out = cur_s;

    // Synchroniser chain, delay flop and sample-valid shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '0;
            end
            dly_r <= '0;
            vld_r <= '0;
        end else begin
            sync_r[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            dly_r <= cur_s;
            vld_r <= {vld_r[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Edge filter, gated until the delay flop carries a genuine sample.
    always_comb begin
        edge_pulse = '0;
        if (vld_r[SYNC_STAGES]) begin
            case (ETYPE)
                EDGE_RISE: edge_pulse = cur_s & ~dly_r;
                EDGE_FALL: edge_pulse = ~cur_s & dly_r;
                EDGE_ANY:  edge_pulse = cur_s ^ dly_r;
                default:   edge_pulse = '0;
            endcase
        end else begin
            edge_pulse = '0;
        end
    end

endmodule

// File: rtl/avalon_pio_ext.sv
// Avalon-MM parallel I/O port with set/clear output access, synchronised
// inputs, sticky edge capture and a maskable level interrupt.
module avalon_pio_ext
    import pio_pkg::*;
#(
    parameter int               WIDTH       = 18,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = 0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    avalon_pio_ext_if.slave     bus,
    input  logic [WIDTH-1:0]    in_port,
    output logic [WIDTH-1:0]    out_port,
    output logic                irq
);

    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] cap_r;
    logic [WIDTH-1:0] data_nxt_s;
    logic [WIDTH-1:0] mask_nxt_s;
    logic [WIDTH-1:0] cap_clr_s;
    logic [WIDTH-1:0] wdata_s;
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] edge_s;
    logic [31:0]      rd_s;
    logic             wr_s;

    pio_edge_detect #(
        .WIDTH       (WIDTH),
        .EDGE_TYPE   (EDGE_TYPE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .sync_out   (sync_s),
        .edge_pulse (edge_s)
    );

    assign wr_s    = bus.chipselect & ~bus.write_n;
    assign wdata_s = bus.writedata[WIDTH-1:0];

    // Decode a bus write into next values for DATA, IRQ_MASK and the capture-clear mask.
    always_comb begin
        data_nxt_s = data_r;
        mask_nxt_s = mask_r;
        cap_clr_s  = '0;
        if (wr_s) begin
            case (bus.address)
                ADDR_DATA:     data_nxt_s = wdata_s;
                ADDR_IRQ_MASK: mask_nxt_s = wdata_s;
                ADDR_EDGE_CAP: cap_clr_s  = wdata_s;
                ADDR_OUTSET:   data_nxt_s = data_r | wdata_s;
                ADDR_OUTCLEAR: data_nxt_s = data_r & ~wdata_s;
                default: begin
                    data_nxt_s = data_r;
                    mask_nxt_s = mask_r;
                    cap_clr_s  = '0;
                end
            endcase
        end else begin
            data_nxt_s = data_r;
            mask_nxt_s = mask_r;
            cap_clr_s  = '0;
        end
    end

    // Register state; a fresh edge overrides a simultaneous clear of the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r <= RESET_VALUE;
            mask_r <= '0;
            cap_r  <= '0;
        end else begin
            data_r <= data_nxt_s;
            mask_r <= mask_nxt_s;
            cap_r  <= (cap_r & ~cap_clr_s) | edge_s;
        end
    end

    // Zero-wait-state read mux, independent of chipselect.
    always_comb begin
        rd_s = 32'h0000_0000;
        case (bus.address)
            ADDR_DATA:     rd_s[WIDTH-1:0] = data_r;
            ADDR_INPUT:    rd_s[WIDTH-1:0] = sync_s;
            ADDR_IRQ_MASK: rd_s[WIDTH-1:0] = mask_r;
            ADDR_EDGE_CAP: rd_s[WIDTH-1:0] = cap_r;
            default:       rd_s = 32'h0000_0000;
        endcase
    end

    assign bus.readdata = rd_s;
    assign out_port     = data_r;
    assign irq          = |(cap_r & mask_r);

endmodule

// File: tb/tb_avalon_pio_ext.sv
// Scoreboard bench for avalon_pio_ext: reads queue their expected value when
// issued and are compared when the read data is sampled.
module tb_avalon_pio_ext;

    localparam int W = 18;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] in_port;
    logic [W-1:0] out_port;
    logic         irq;

    int           checks = 0;
    int           errors = 0;
    logic [31:0]  exp_q[$];
    string        tag_q[$];

    always #5 clk = ~clk;

    avalon_pio_ext_if bus ();

    avalon_pio_ext #(
        .WIDTH       (W),
        .RESET_VALUE (18'h000F0),
        .EDGE_TYPE   (0),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .in_port  (in_port),
        .out_port (out_port),
        .irq      (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a read: expectation goes on the scoreboard, popped when readdata is sampled.
    task automatic rd_exp(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        bus.address = addr;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        chk(tag_q.pop_front(), bus.readdata, exp_q.pop_front());
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    initial begin
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        in_port        = '1;
        reset_n        = 1'b1;
        #2 reset_n     = 1'b0;

        // Reset state
        #1;
        chk("rst_out", 32'(out_port), 32'h0000_00F0);
        chk("rst_irq", 32'(irq), 32'h0);
        rd_exp(3'd3, 32'h0, "rst_cap");
        rd_exp(3'd0, 32'h0000_00F0, "rst_data");
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Inputs held high through reset release: no capture
        repeat (10) @(negedge clk);
        rd_exp(3'd3, 32'h0, "no_spurious");
        rd_exp(3'd1, 32'h0003_FFFF, "input_ones");

        // DATA / OUTCLEAR / OUTSET
        wr(3'd0, 32'hFFFF_FFFF);
        wr(3'd5, 32'h0000_0003);
        wr(3'd4, 32'h0001_0000);
        chk("out_setclr", 32'(out_port), 32'h0003_FFFC);
        rd_exp(3'd0, 32'h0003_FFFC, "rd_data");

        // Falling edges on every bit capture nothing with rising-edge filter
        @(negedge clk);
        in_port = '0;
        repeat (5) @(negedge clk);
        rd_exp(3'd3, 32'h0, "fall_ignored");
        rd_exp(3'd1, 32'h0, "input_zero");
        wr(3'd2, 32'h0000_0001);
        rd_exp(3'd2, 32'h1, "mask_rd");

        // Rising edge latency: set after exactly 3 clocks
        @(negedge clk);
        in_port[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rd_exp(3'd3, 32'h0, "lat2_clear");
        chk("lat2_irq", 32'(irq), 32'h0);
        @(negedge clk);
        rd_exp(3'd3, 32'h1, "lat3_set");
        chk("lat3_irq", 32'(irq), 32'h1);

        // Clear coinciding with a new edge: edge wins
        in_port[0] = 1'b0;
        repeat (5) @(negedge clk);
        in_port[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        wr(3'd3, 32'h0000_0001);
        rd_exp(3'd3, 32'h1, "edge_wins");
        chk("edge_wins_irq", 32'(irq), 32'h1);
        wr(3'd3, 32'h0000_0001);
        rd_exp(3'd3, 32'h0, "clr_cap");
        chk("clr_irq", 32'(irq), 32'h0);

        // Writing 0 leaves captured bits; mask gates irq
        @(negedge clk);
        in_port = 18'h00004;
        repeat (5) @(negedge clk);
        rd_exp(3'd3, 32'h4, "cap_bit2");
        chk("masked_irq", 32'(irq), 32'h0);
        wr(3'd3, 32'h0000_0000);
        rd_exp(3'd3, 32'h4, "w0_keeps");
        wr(3'd2, 32'h0000_0004);
        chk("unmasked_irq", 32'(irq), 32'h1);

        // Reserved offset write and reads
        wr(3'd6, 32'hFFFF_FFFF);
        rd_exp(3'd0, 32'h0003_FFFC, "res_data");
        rd_exp(3'd2, 32'h4, "res_mask");
        rd_exp(3'd3, 32'h4, "res_cap");
        rd_exp(3'd6, 32'h0, "rd_res6");
        rd_exp(3'd7, 32'h0, "rd_res7");
        rd_exp(3'd4, 32'h0, "rd_outset");
        rd_exp(3'd5, 32'h0, "rd_outclr");
        rd_exp(3'd1, 32'h4, "input_bit2");
        chk("res_out", 32'(out_port), 32'h0003_FFFC);

        // Reset asserted mid-write aborts it
        @(negedge clk);
        bus.address    = 3'd0;
        bus.writedata  = 32'h0001_2345;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        #2 reset_n     = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        chk("abort_out", 32'(out_port), 32'h0000_00F0);
        chk("abort_irq", 32'(irq), 32'h0);
        rd_exp(3'd2, 32'h0, "abort_mask");
        rd_exp(3'd3, 32'h0, "abort_cap");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_out", 32'(out_port), 32'h0000_00F0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
